// File: rtl/mfp_bot_evt_sync.sv
// Multi-channel Rojobot update synchroniser: per-channel edge detect, BotInfo
// snapshot, pending/overrun tracking, and one prioritised maskable interrupt.
module mfp_bot_evt_sync #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ID_W        = 2
) (
  input  logic                   SI_ClkIn,
  input  logic                   SI_Reset_N,
  input  logic [N_CH-1:0]        IO_BotUpdt,
  input  logic [N_CH*DATA_W-1:0] IO_BotInfo_in,
  input  logic [N_CH-1:0]        IO_IntMask,
  input  logic                   IO_INT_ACK,
  input  logic [ID_W-1:0]        IO_AckId,
  input  logic                   IO_OvrClr,
  output logic                   IO_BotUpdt_Sync,
  output logic [ID_W-1:0]        IO_IntId,
  output logic [DATA_W-1:0]      IO_BotInfo,
  output logic [N_CH-1:0]        IO_Pending,
  output logic [N_CH-1:0]        IO_Overrun
);

  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [DATA_W-1:0]      snap_q [N_CH];
  logic [N_CH-1:0]        sync_last_c;
  logic [N_CH-1:0]        edge_q;
  logic [N_CH-1:0]        evt_c;
  logic [N_CH-1:0]        ack_c;
  logic [N_CH-1:0]        pend_q;
  logic [N_CH-1:0]        ovr_q;
  logic [N_CH-1:0]        req_c;
  logic [ID_W-1:0]        nxt_id_c;
  logic [DATA_W-1:0]      nxt_info_c;

  // Last sync stage and ID-addressed acknowledge decode per channel
  always_comb begin
    sync_last_c = '0;
    ack_c       = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      sync_last_c[k] = sync_q[k][SYNC_STAGES-1];
      ack_c[k]       = IO_INT_ACK && (IO_AckId == ID_W'(k));
    end
  end

  assign evt_c = sync_last_c & ~edge_q;
  assign req_c = pend_q & IO_IntMask;

  // Synchroniser chains and rising-edge history
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      for (int k = 0; k < int'(N_CH); k++) sync_q[k] <= '0;
      edge_q <= '0;
    end else begin
      for (int k = 0; k < int'(N_CH); k++)
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], IO_BotUpdt[k]};
      edge_q <= sync_last_c;
    end
  end

  // An ack coinciding with a new event consumes the old one, so no overrun
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= evt_c | (pend_q & ~ack_c);
      ovr_q  <= (ovr_q & {N_CH{~IO_OvrClr}}) | (evt_c & pend_q & ~ack_c);
    end
  end

  // BotInfo is stable while the strobe is high, so the late capture is safe
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      for (int k = 0; k < int'(N_CH); k++) snap_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(N_CH); k++)
        if (evt_c[k]) snap_q[k] <= IO_BotInfo_in[k*DATA_W +: DATA_W];
    end
  end

  // Lowest-index masked pending channel wins; ID and data selected together
  always_comb begin
    nxt_id_c   = '0;
    nxt_info_c = snap_q[0];
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if (req_c[k]) begin
        nxt_id_c   = ID_W'(k);
        nxt_info_c = snap_q[k];
      end
    end
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      IO_BotUpdt_Sync <= 1'b0;
      IO_IntId        <= '0;
      IO_BotInfo      <= '0;
    end else begin
      IO_BotUpdt_Sync <= |req_c;
      IO_IntId        <= nxt_id_c;
      IO_BotInfo      <= nxt_info_c;
    end
  end

  assign IO_Pending = pend_q;
  assign IO_Overrun = ovr_q;

endmodule

// File: tb/tb_mfp_bot_evt_sync.sv
// Bench for mfp_bot_evt_sync: directed scenarios plus random strobes, all
// outputs compared every cycle against a transaction-level reference model.
module tb_mfp_bot_evt_sync;

  localparam int unsigned N_CH = 4;
  localparam int unsigned S    = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_CH-1:0]   upd;
  logic [N_CH-1:0]   mask;
  logic [DW-1:0]     din [N_CH];
  logic [N_CH*DW-1:0] din_flat;
  logic              ack;
  logic [IW-1:0]     ack_id;
  logic              ovrclr;

  logic              o_sync;
  logic [IW-1:0]     o_id;
  logic [DW-1:0]     o_info;
  logic [N_CH-1:0]   o_pend;
  logic [N_CH-1:0]   o_ovr;

  always #10 clk = ~clk;

  always_comb
    for (int k = 0; k < int'(N_CH); k++) din_flat[k*DW +: DW] = din[k];

  mfp_bot_evt_sync #(
    .N_CH(N_CH), .SYNC_STAGES(S), .DATA_W(DW), .ID_W(IW)
  ) dut (
    .SI_ClkIn       (clk),
    .SI_Reset_N     (rst_n),
    .IO_BotUpdt     (upd),
    .IO_BotInfo_in  (din_flat),
    .IO_IntMask     (mask),
    .IO_INT_ACK     (ack),
    .IO_AckId       (ack_id),
    .IO_OvrClr      (ovrclr),
    .IO_BotUpdt_Sync(o_sync),
    .IO_IntId       (o_id),
    .IO_BotInfo     (o_info),
    .IO_Pending     (o_pend),
    .IO_Overrun     (o_ovr)
  );

  // Reference model state: input sample history, per-channel flags, outputs
  bit            h      [N_CH][S+1];
  bit            m_pend [N_CH];
  bit            m_ovr  [N_CH];
  logic [DW-1:0] m_snap [N_CH];
  bit            m_sync;
  int            m_id;
  logic [DW-1:0] m_info;

  int n_chk  = 0;
  int n_pass = 0;
  int hold [N_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < int'(N_CH); k++) begin
      for (int j = 0; j <= int'(S); j++) h[k][j] = 1'b0;
      m_pend[k] = 1'b0;
      m_ovr[k]  = 1'b0;
      m_snap[k] = '0;
    end
    m_sync = 1'b0;
    m_id   = 0;
    m_info = '0;
  endtask

  // Advance model and DUT by one clock, then compare every output
  task automatic tick();
    bit            a, ev, s;
    int            id;
    logic [DW-1:0] inf;
    logic [N_CH-1:0] pv, ov;
    if (!rst_n) begin
      model_reset();
    end else begin
      s = 1'b0; id = 0; inf = m_snap[0];
      for (int k = 0; k < int'(N_CH); k++)
        if (!s && m_pend[k] && mask[k]) begin s = 1'b1; id = k; inf = m_snap[k]; end
      if (ovrclr) for (int k = 0; k < int'(N_CH); k++) m_ovr[k] = 1'b0;
      for (int k = 0; k < int'(N_CH); k++) begin
        a  = ack && (int'(ack_id) == k);
        // rising edge sampled S clocks ago becomes an event now
        ev = h[k][S-1] && !h[k][S];
        if (ev) begin
          if (m_pend[k] && !a) m_ovr[k] = 1'b1;
          m_pend[k] = 1'b1;
          m_snap[k] = din[k];
        end else if (a) begin
          m_pend[k] = 1'b0;
        end
        for (int j = int'(S); j > 0; j--) h[k][j] = h[k][j-1];
        h[k][0] = upd[k];
      end
      m_sync = s; m_id = id; m_info = inf;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < int'(N_CH); k++) begin
      pv[k] = m_pend[k];
      ov[k] = m_ovr[k];
    end
    check("sync",    32'(o_sync), 32'(m_sync));
    check("int_id",  32'(o_id),   32'(m_id));
    check("info",    o_info,      m_info);
    check("pending", 32'(o_pend), 32'(pv));
    check("overrun", 32'(o_ovr),  32'(ov));
  endtask

  task automatic do_ack(input int id);
    ack    = 1'b1;
    ack_id = IW'(id);
    tick();
    ack    = 1'b0;
  endtask

  initial begin
    upd = '0; mask = '0; ack = 1'b0; ack_id = '0; ovrclr = 1'b0;
    for (int k = 0; k < int'(N_CH); k++) begin din[k] = '0; hold[k] = 0; end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_sync", 32'(o_sync), 32'd0);
    check("rst_id",   32'(o_id),   32'd0);
    check("rst_info", o_info,      32'd0);
    check("rst_pend", 32'(o_pend), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) tick();

    // Ch2 single event despite a 4-cycle strobe
    mask = 4'hF;
    din[2] = 32'h1234_5678;
    upd[2] = 1'b1;
    repeat (3) tick();
    check("ch2_pend_lat", 32'(o_pend[2]), 32'd1);
    check("ch2_sync_early", 32'(o_sync), 32'd0);
    tick();
    upd[2] = 1'b0;
    check("ch2_sync", 32'(o_sync), 32'd1);
    check("ch2_id",   32'(o_id),   32'd2);
    check("ch2_info", o_info,      32'h1234_5678);
    repeat (4) tick();
    check("ch2_no_ovr", 32'(o_ovr), 32'd0);
    do_ack(2);
    tick();
    check("ch2_ack_sync", 32'(o_sync), 32'd0);

    // Ch1 and ch3 together: lowest index served first
    din[1] = 32'h1111_0001;
    din[3] = 32'h3333_0003;
    upd[1] = 1'b1; upd[3] = 1'b1;
    repeat (3) tick();
    upd[1] = 1'b0; upd[3] = 1'b0;
    tick();
    check("dual_id1",   32'(o_id), 32'd1);
    check("dual_info1", o_info,    32'h1111_0001);
    do_ack(1);
    tick();
    check("dual_id3",   32'(o_id), 32'd3);
    check("dual_info3", o_info,    32'h3333_0003);
    do_ack(3);
    tick();
    check("dual_done", 32'(o_sync), 32'd0);

    // Ch0 overrun, then clear
    din[0] = 32'h0000_00D1;
    upd[0] = 1'b1;
    repeat (3) tick();
    upd[0] = 1'b0;
    repeat (3) tick();
    din[0] = 32'hAAAA_0001;
    upd[0] = 1'b1;
    repeat (3) tick();
    upd[0] = 1'b0;
    repeat (2) tick();
    check("ovr_set",  32'(o_ovr[0]), 32'd1);
    check("ovr_info", o_info,        32'hAAAA_0001);
    ovrclr = 1'b1;
    tick();
    ovrclr = 1'b0;
    check("ovr_clr", 32'(o_ovr[0]), 32'd0);

    // Ack to ch0 on the very cycle a new ch0 event lands
    din[0] = 32'hBEEF_0002;
    upd[0] = 1'b1;
    repeat (S) tick();
    ack = 1'b1; ack_id = 2'd0;
    tick();
    ack = 1'b0;
    check("ackevt_pend", 32'(o_pend[0]), 32'd1);
    check("ackevt_ovr",  32'(o_ovr[0]),  32'd0);
    tick();
    check("ackevt_info", o_info, 32'hBEEF_0002);
    upd[0] = 1'b0;
    tick();
    do_ack(0);
    tick();

    // Masked channel pends silently; unmask raises interrupt next cycle
    mask = 4'b1110;
    din[0] = 32'hC0C0_0000;
    upd[0] = 1'b1;
    repeat (3) tick();
    upd[0] = 1'b0;
    tick();
    check("mask_pend", 32'(o_pend[0]), 32'd1);
    check("mask_sync", 32'(o_sync),    32'd0);
    mask = 4'hF;
    tick();
    check("unmask_sync", 32'(o_sync), 32'd1);
    check("unmask_id",   32'(o_id),   32'd0);
    do_ack(1);
    check("bad_ack_pend", 32'(o_pend), 32'd1);
    check("bad_ack_sync", 32'(o_sync), 32'd1);
    do_ack(0);
    tick();

    // Async reset mid-operation with a strobe still high across release
    din[1] = 32'h5A5A_1111;
    upd[1] = 1'b1;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_pend", 32'(o_pend), 32'd0);
    check("arst_sync", 32'(o_sync), 32'd0);
    check("arst_info", o_info,      32'd0);
    model_reset();
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    repeat (S) tick();
    check("inflight_early", 32'(o_pend[1]), 32'd0);
    tick();
    check("inflight_evt", 32'(o_pend[1]), 32'd1);
    upd[1] = 1'b0;
    tick();
    do_ack(1);
    tick();

    // Random strobes, acks, clears and mask changes
    repeat (3000) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        if (upd[k]) begin
          hold[k]++;
          if (hold[k] >= 2 && $urandom_range(3) == 0) upd[k] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          din[k]  = $urandom;
          upd[k]  = 1'b1;
          hold[k] = 0;
        end
      end
      ack    = ($urandom_range(3) == 0);
      ack_id = IW'($urandom_range(N_CH - 1));
      ovrclr = ($urandom_range(15) == 0);
      if ($urandom_range(15) == 0) mask = N_CH'($urandom);
      tick();
    end
    ack = 1'b0;
    ovrclr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
